order_buffer: RTL and testbench

Parametrised collect-then-drain buffer for the check-in/pickup datapath. It gathers a character stream until a terminator arrives, keeping only characters at or above a threshold. It then replays the kept items in FIFO order (check-in) or LIFO order (pickup), with a downstream `out_ready` backpressure handshake, an overflow flag and a live occupancy count. It replaces the fixed 8×16 FIFO-only stage, and its storage is a circular buffer rather than a shift array.

---
 rtl/order_buffer_pkg.sv | 15 +
 rtl/order_buffer_mem.sv | 23 ++
 rtl/order_buffer.sv | 124 ++++++++++++
 tb/tb_order_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/order_buffer_pkg.sv
// Shared constants for the order_buffer collect-then-drain stage.
package order_buffer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_LIFO = 1'b1;

  localparam logic [7:0] TERM_CHAR     = 8'h24;
  localparam logic [7:0] KEEP_MIN_CHAR = 8'h41;

endpackage

// File: rtl/order_buffer_mem.sv
// Item storage: register array, one synchronous write port, one asynchronous read port.
module order_buffer_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/order_buffer.sv
// Collect items up to a terminator, then replay them in FIFO or LIFO order
// with out_ready backpressure; circular-buffer storage.
module order_buffer
  import order_buffer_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       DEPTH    = 16,
  parameter logic [DATA_W-1:0] TERM     = DATA_W'(TERM_CHAR),
  parameter logic [DATA_W-1:0] KEEP_MIN = DATA_W'(KEEP_MIN_CHAR)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic                       mode,
  input  logic [DATA_W-1:0]          in,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out,
  output logic                       valid,
  output logic                       done,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     raddr;
  logic              mode_q;
  logic              start;
  logic              wr_en;
  logic              drop_full;
  logic              pop;
  logic [DATA_W-1:0] rdata;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    wr_en     = 1'b0;
    drop_full = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (ready) begin
          start     = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (in == TERM) begin
          state_nxt = (count != '0) ? ST_WRITE : ST_DONE;
        end else if (in >= KEEP_MIN) begin
          if (count == CW'(DEPTH)) drop_full = 1'b1;
          else                     wr_en     = 1'b1;
        end
      end
      ST_WRITE: begin
        if (out_ready) begin
          pop = 1'b1;
          if (count == CW'(1)) state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pointers, occupancy, overflow and latched mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      mode_q   <= MODE_FIFO;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      mode_q   <= mode;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end
      if (drop_full) overflow <= 1'b1;
      if (pop) begin
        if (mode_q == MODE_LIFO) wr_ptr <= wr_ptr - AW'(1);
        else                     rd_ptr <= rd_ptr + AW'(1);
        count <= count - CW'(1);
      end
    end
  end

  // LIFO head is the most recently written slot.
  assign raddr = (mode_q == MODE_LIFO) ? (wr_ptr - AW'(1)) : rd_ptr;

  order_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign valid = (state == ST_WRITE);
  assign done  = (state == ST_DONE);
  assign out   = valid ? rdata : '0;

endmodule

// File: tb/tb_order_buffer.sv
// Directed bench for order_buffer: ordering, overflow, backpressure, empty drain, reset.
module tb_order_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CW     = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          mode;
  logic [7:0]    in;
  logic          out_ready;
  logic [7:0]    out;
  logic          valid;
  logic          done;
  logic          overflow;
  logic [CW-1:0] count;

  int nvec = 0;
  int nerr = 0;
  int ncyc;

  logic [7:0] stim[$];
  logic [7:0] expq[$];
  logic [7:0] got[$];

  always #5 clk = ~clk;

  order_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .mode      (mode),
    .in        (in),
    .out_ready (out_ready),
    .out       (out),
    .valid     (valid),
    .done      (done),
    .overflow  (overflow),
    .count     (count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Start a transaction from IDLE/DONE and stream stim; returns right after the last item is driven.
  task automatic feed(input logic m);
    @(negedge clk);
    ready = 1'b1;
    mode  = m;
    @(negedge clk);
    ready = 1'b0;
    mode  = ~m;
    check_val("start_cnt",   32'(count),    32'd0);
    check_val("start_ovf",   32'(overflow), 32'd0);
    check_val("start_done",  32'(done),     32'd0);
    check_val("start_valid", 32'(valid),    32'd0);
    for (int i = 0; i < stim.size(); i++) begin
      if (i > 0) @(negedge clk);
      in = stim[i];
    end
  endtask

  // Accept items until done; optionally stall stall_len cycles once stall_at items have been taken.
  task automatic drain(input int stall_at, input int stall_len, input logic [7:0] stall_exp,
                       output int cycles);
    int pops;
    int left;
    int guard;
    pops   = 0;
    left   = stall_len;
    cycles = 0;
    guard  = 0;
    got.delete();
    @(negedge clk);
    while (!done && guard < 200) begin
      if (valid) begin
        check_val("drain_cnt", 32'(count), 32'(expq.size() - pops));
        if (pops == stall_at && left > 0) begin
          check_val("bp_hold_out", 32'(out), 32'(stall_exp));
          out_ready = 1'b0;
          left--;
        end else begin
          out_ready = 1'b1;
          got.push_back(out);
          pops++;
        end
      end
      cycles++;
      guard++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    check_val("drain_bound", 32'(done), 32'd1);
  endtask

  task automatic compare_out(input string tag);
    check_val({tag, "_n"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      check_val(tag, 32'(got[i]), 32'(expq[i]));
  endtask

  initial begin
    rst       = 1'b0;
    ready     = 1'b0;
    mode      = 1'b0;
    in        = 8'h00;
    out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    check_val("rst_out",   32'(out),      32'd0);
    check_val("rst_valid", 32'(valid),    32'd0);
    check_val("rst_done",  32'(done),     32'd0);
    check_val("rst_ovf",   32'(overflow), 32'd0);
    check_val("rst_cnt",   32'(count),    32'd0);
    rst = 1'b1;

    // FIFO order
    stim = '{8'h41, 8'h62, 8'h33, 8'h43, 8'h24};
    expq = '{8'h41, 8'h62, 8'h43};
    feed(1'b0);
    drain(-1, 0, 8'h00, ncyc);
    compare_out("fifo");
    check_val("fifo_cycles", 32'(ncyc), 32'd3);

    // LIFO order
    expq = '{8'h43, 8'h62, 8'h41};
    feed(1'b1);
    drain(-1, 0, 8'h00, ncyc);
    compare_out("lifo");
    check_val("lifo_cycles", 32'(ncyc), 32'd3);

    // Overflow: 18 letters into 16 slots
    stim.delete();
    expq.delete();
    for (int i = 0; i < 18; i++) stim.push_back(8'(8'h41 + i));
    stim.push_back(8'h24);
    for (int i = 0; i < 16; i++) expq.push_back(8'(8'h41 + i));
    feed(1'b0);
    drain(-1, 0, 8'h00, ncyc);
    compare_out("ovf");
    check_val("ovf_cycles", 32'(ncyc),     32'd16);
    check_val("ovf_flag",   32'(overflow), 32'd1);

    // Empty drain; restart from DONE clears the overflow left above
    stim = '{8'h31, 8'h24};
    expq.delete();
    feed(1'b0);
    drain(-1, 0, 8'h00, ncyc);
    check_val("empty_cycles", 32'(ncyc),  32'd0);
    check_val("empty_valid",  32'(valid), 32'd0);
    check_val("empty_n",      32'(got.size()), 32'd0);

    // Backpressure: 2-cycle stall after the second pop
    stim = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h24};
    expq = '{8'h41, 8'h42, 8'h43, 8'h44};
    feed(1'b0);
    drain(2, 2, 8'h43, ncyc);
    compare_out("bp");
    check_val("bp_cycles", 32'(ncyc), 32'd6);

    // Reset in the middle of a drain
    stim = '{8'h41, 8'h42, 8'h43, 8'h24};
    feed(1'b0);
    @(negedge clk);
    check_val("mid_first", 32'(out), 32'h41);
    @(negedge clk);
    check_val("mid_second", 32'(out), 32'h42);
    #2 rst = 1'b0;
    #1;
    check_val("arst_out",   32'(out),      32'd0);
    check_val("arst_valid", 32'(valid),    32'd0);
    check_val("arst_done",  32'(done),     32'd0);
    check_val("arst_cnt",   32'(count),    32'd0);
    check_val("arst_ovf",   32'(overflow), 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    ready = 1'b0;
    in    = 8'h41;
    @(negedge clk);
    @(negedge clk);
    check_val("idle_cnt",   32'(count), 32'd0);
    check_val("idle_done",  32'(done),  32'd0);
    check_val("idle_valid", 32'(valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
